// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and architectural constants.
package cpu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    // Fetch-stage sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } fetch_state_t;

    // PC after reset.
    localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // addi x0, x0, 0
    localparam logic [XLEN_DEFAULT-1:0] INSTR_NOP = 32'h0000_0013;

endpackage : cpu_pkg

// File: rtl/pc_unit.sv
// Program counter register with next-PC selection and misaligned-target detection.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_commit,
    input  logic              i_branch_taken,
    input  logic [ADDR_W-1:0] i_branch_target,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_err_misalign
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_AT_RESET = RESET_PC & ALIGN_MASK;

    logic [ADDR_W-1:0] w_next_pc;
    logic              w_misalign;

    // Next PC: word-aligned branch target when taken, else sequential (wraps).
    always_comb begin
        w_next_pc  = o_pc + PC_STEP;
        w_misalign = 1'b0;
        if (i_branch_taken) begin
            w_next_pc  = i_branch_target & ALIGN_MASK;
            w_misalign = (i_branch_target[1:0] != 2'b00);
        end
    end

    // PC register and sticky misalign flag, updated only on a commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_pc           <= PC_AT_RESET;
            o_err_misalign <= 1'b0;
        end else if (i_commit) begin
            o_pc <= w_next_pc;
            if (w_misalign) begin
                o_err_misalign <= 1'b1;
            end
        end
    end

endmodule : pc_unit

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, reads one instruction per fetch and hands it to IF/ID.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter int unsigned        INSTR_W  = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fetch_start,
    output logic               fetch_done,
    input  logic               if_id_wren,
    input  logic               wb_if_wren,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc4,
    output logic [ADDR_W-1:0]  pc,
    output logic               err_protocol,
    output logic               err_misalign
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK  = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] PC_STEP     = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] PC_AT_RESET = RESET_PC & ALIGN_MASK;

    fetch_state_t       r_state;
    logic [INSTR_W-1:0] r_buf;
    logic               r_done_pend;
    logic               r_start_pend;

    logic               w_in_idle;
    logic               w_commit;
    logic               w_start;
    logic               w_err_evt;

    // PC register lives in the sub-unit; commits are only honoured in IDLE.
    pc_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_unit (
        .clk             (clk),
        .reset_n         (reset_n),
        .i_commit        (w_commit),
        .i_branch_taken  (branch_taken),
        .i_branch_target (branch_target),
        .o_pc            (pc),
        .o_err_misalign  (err_misalign)
    );

    // Event qualification and illegal-pulse detection.
    always_comb begin
        w_in_idle = (r_state == IDLE);
        w_commit  = wb_if_wren && w_in_idle;
        w_start   = (fetch_start || r_start_pend) && w_in_idle;
        w_err_evt = 1'b0;
        if (fetch_start && !w_in_idle)           w_err_evt = 1'b1;
        if (wb_if_wren && !w_in_idle)            w_err_evt = 1'b1;
        if (if_id_wren && (r_state != HOLD))     w_err_evt = 1'b1;
        if (imem_rvalid && (r_state != WAIT))    w_err_evt = 1'b1;
        if (fetch_start && wb_if_wren && w_in_idle) w_err_evt = 1'b1;
    end

    // Fetch FSM with registered memory, handshake and IF/ID outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_buf        <= INSTR_W'(INSTR_NOP);
            r_done_pend  <= 1'b0;
            r_start_pend <= 1'b0;
            fetch_done   <= 1'b0;
            imem_req     <= 1'b0;
            imem_addr    <= PC_AT_RESET;
            if_id_instr  <= '0;
            if_id_pc     <= '0;
            if_id_pc4    <= '0;
            err_protocol <= 1'b0;
        end else begin
            fetch_done  <= r_done_pend;
            r_done_pend <= 1'b0;
            if (w_err_evt) begin
                err_protocol <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    if (w_start && w_commit) begin
                        // PC changes this edge; launch the read from the new PC next cycle.
                        r_start_pend <= 1'b1;
                    end else if (w_start) begin
                        r_start_pend <= 1'b0;
                        r_state      <= REQ;
                        imem_req     <= 1'b1;
                        imem_addr    <= pc & ALIGN_MASK;
                    end
                end
                REQ: begin
                    if (imem_ready) begin
                        r_state  <= WAIT;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        r_buf       <= imem_rdata;
                        r_done_pend <= 1'b1;
                        r_state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (if_id_wren) begin
                        if_id_instr <= r_buf;
                        if_id_pc    <= pc;
                        if_id_pc4   <= pc + PC_STEP;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : instruction_fetch

// File: doc/instruction_fetch.md
# instruction_fetch

- Fetch stage of the multi-cycle CPU.
- Owns the program counter and issues one instruction-memory read per instruction over a req/ready + rvalid handshake.
- Buffers the returned word and presents it to the IF/ID latch when the stage controller pulses `if_id_wren`.
- Applies the next-PC (sequential or branch target) when the controller pulses `wb_if_wren` at the end of write-back.

## Interface
- `ADDR_W`, 32, PC / instruction address width
- `INSTR_W`, 32, instruction word width
- `RESET_PC`, 32'h0000_0000, PC value after reset
- `clk`  in  1  single clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `fetch_start`  in  1  controller pulse (STAGE_IF): begin fetch at current PC
- `fetch_done`  out  1  one-cycle pulse: instruction buffered and valid
- `if_id_wren`  in  1  copy buffered instruction/PC to IF/ID outputs
- `wb_if_wren`  in  1  commit next PC
- `branch_taken`  in  1  select `branch_target` at commit
- `branch_target`  in  ADDR_W  redirect address from WB
- `imem_req`  out  1  read request valid
- `imem_addr`  out  ADDR_W  read address (always word-aligned)
- `imem_ready`  in  1  memory accepts request this cycle
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  INSTR_W  read data
- `if_id_instr`  out  INSTR_W  latched instruction
- `if_id_pc`  out  ADDR_W  PC of latched instruction
- `if_id_pc4`  out  ADDR_W  `if_id_pc` + 4
- `pc`  out  ADDR_W  current architectural PC
- `err_protocol`  out  1  sticky: illegal pulse/handshake seen
- `err_misalign`  out  1  sticky: branch target had nonzero bits [1:0]

## Operation
- FSM states: `IDLE`, `REQ`, `WAIT`, `HOLD`.
- `IDLE`:
  - `fetch_start` → `REQ`.
  - `wb_if_wren` updates PC: `branch_taken ? {branch_target[ADDR_W-1:2],2'b00} : pc+4`.
  - Sum wraps modulo 2^ADDR_W.
  - `err_misalign` sets if the taken target has nonzero bits [1:0].
- `REQ`:
  - `imem_req`=1 and `imem_addr`=`pc`, both held stable until `imem_ready`.
  - `imem_ready` → `WAIT`.
- `WAIT`:
  - `imem_rvalid` → capture `imem_rdata` into the internal buffer, pulse `fetch_done` next cycle, → `HOLD`.
- `HOLD`:
  - `if_id_wren` → `if_id_instr`<=buffer, `if_id_pc`<=pc, `if_id_pc4`<=pc+4, → `IDLE`.
- Illegal events: each is ignored and sets `err_protocol`; the FSM and PC are unchanged.
  - `fetch_start` outside `IDLE`.
  - `wb_if_wren` outside `IDLE`.
  - `if_id_wren` outside `HOLD`.
  - `imem_rvalid` outside `WAIT`.
- Simultaneous `fetch_start` and `wb_if_wren` in `IDLE`: PC commit wins, the fetch starts next cycle from the new PC, and `err_protocol` sets.
- Error flags clear only on reset.

## Timing
- Reset (async assert, synchronous-release assumed upstream):
  - State `IDLE`, `pc`=`RESET_PC`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `fetch_done`=0.
  - `if_id_instr`=0, `if_id_pc`=0, `if_id_pc4`=0.
  - Both error flags 0.
- All outputs are registered.
- Minimum latency, with `fetch_start` sampled at edge 0:
  - `imem_req` high after edge 0.
  - `imem_ready` sampled at edge 1.
  - `imem_rvalid` sampled at edge 2.
  - `fetch_done` high for the single cycle after edge 3.
- `if_id_*` update on the edge that samples `if_id_wren`.
- `pc` updates on the edge that samples `wb_if_wren`.
- `imem_rvalid` in the same cycle as acceptance (state `REQ`) is illegal and sets `err_protocol`.
- Reset mid-transaction (`REQ`/`WAIT`): the request is dropped, no `fetch_done` is produced, and a late `imem_rvalid` after reset sets `err_protocol`.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum (`IDLE`/`REQ`/`WAIT`/`HOLD`).
  - `RESET_PC` default.
  - `INSTR_NOP` constant.
- One sub-module, `pc_unit`:
  - PC register with async reset.
  - Next-PC mux and alignment/misalign detection.
  - Enabled by the FSM's commit strobe.

## Test plan
- Reset, then fetch with `imem_ready` and `imem_rvalid` each after 1 cycle, rdata 32'h0010_0093 → `imem_addr`=0, `fetch_done` pulse 3 cycles after `fetch_start`; after `if_id_wren`, `if_id_instr`=32'h0010_0093, `if_id_pc`=0, `if_id_pc4`=4.
- `wb_if_wren` with `branch_taken`=0, then again with `branch_taken`=1, target 32'h0000_0100 → `pc` 0→4→0x100; next fetch `imem_addr`=0x100.
- `imem_ready` held low for 5 cycles → `imem_req` and `imem_addr` stay stable throughout; exactly one acceptance occurs.
- Target 32'h0000_0102 taken → `pc`=0x100, `err_misalign`=1 and sticky.
- `pc`=32'hFFFF_FFFC, sequential commit → `pc`=0.
- `fetch_start` in `WAIT`, and `if_id_wren` in `IDLE` → both ignored, `err_protocol`=1.
- `reset_n` low during `WAIT`, then rvalid → outputs return to reset values and `fetch_done` stays 0.
